// File: rtl/breath_led_pkg.sv
// Shared definitions for the breathing LED array: mode encodings and the
// prescaler ratio derived from the clock, PWM rate and duty resolution.
package breath_led_pkg;

   typedef enum logic [1:0] {
      MODE_OFF    = 2'b00,
      MODE_ON     = 2'b01,
      MODE_BREATH = 2'b10,
      MODE_BLINK  = 2'b11
   } led_mode_t;

   // Clock cycles per PWM slot, floored; zero means the clock is too slow.
   function automatic int calc_presc(input int clock_frq, input int pwm_frq, input int duty_w);
      return clock_frq / (pwm_frq * (1 << duty_w));
   endfunction

endpackage

// File: rtl/breath_pwm_ch.sv
// One LED channel: period-aligned shadow of mode and breath duty, mode
// decode and slot compare, with a registered LED output.
module breath_pwm_ch
   import breath_led_pkg::*;
#(
   parameter int DUTY_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [1:0]        mode,
   input  logic [DUTY_W:0]   phase,
   input  logic [DUTY_W-1:0] slot,
   output logic              led
);

   led_mode_t         mode_q;
   logic [DUTY_W-1:0] duty;
   logic [DUTY_W-1:0] duty_q;
   logic              blink_q;
   logic              led_d;

   // Rising half of the triangle uses the phase directly, falling half mirrors it.
   assign duty = phase[DUTY_W] ? ~phase[DUTY_W-1:0] : phase[DUTY_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q  <= MODE_OFF;
         duty_q  <= '0;
         blink_q <= 1'b0;
      end else if (load) begin
         mode_q  <= led_mode_t'(mode);
         duty_q  <= duty;
         blink_q <= ~phase[DUTY_W];
      end
   end

   always_comb begin
      led_d = 1'b0;
      case (mode_q)
         MODE_OFF:    led_d = 1'b0;
         MODE_ON:     led_d = 1'b1;
         MODE_BREATH: led_d = (slot < duty_q);
         MODE_BLINK:  led_d = blink_q;
         default:     led_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) led <= 1'b0;
      else        led <= led_d;
   end

endmodule

// File: rtl/breath_led_array.sv
// Multi-channel breathing LED driver: shared prescaler, PWM slot, step and
// phase counters feeding one breath_pwm_ch per channel.
module breath_led_array
   import breath_led_pkg::*;
#(
   parameter int CLOCK_FRQ    = 50000000,
   parameter int PWM_FRQ      = 1000,
   parameter int DUTY_W       = 8,
   parameter int N_CH         = 4,
   parameter int STEP_PERIODS = 2,
   parameter int PHASE_OFS    = 0
) (
   input  logic              CLK,
   input  logic              RSTN,
   input  logic [2*N_CH-1:0] MODE,
   input  logic              PAUSE,
   output logic [N_CH-1:0]   LED
);

   localparam int PRESC   = calc_presc(CLOCK_FRQ, PWM_FRQ, DUTY_W);
   localparam int PRESC_W = (PRESC > 1) ? $clog2(PRESC) : 1;
   localparam int STEP_W  = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC - 1);
   localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(STEP_PERIODS - 1);

   if (PRESC < 1) begin : g_bad_presc
      $error("breath_led_array: CLOCK_FRQ/(PWM_FRQ*2^DUTY_W) must be at least 1");
   end
   if (STEP_PERIODS < 1) begin : g_bad_step
      $error("breath_led_array: STEP_PERIODS must be at least 1");
   end

   logic [PRESC_W-1:0] presc_cnt;
   logic [DUTY_W-1:0]  slot_cnt;
   logic [STEP_W-1:0]  step_cnt;
   logic [DUTY_W:0]    phase_q;
   logic               tick;
   logic               boundary;

   assign tick     = (presc_cnt == PRESC_LAST);
   assign boundary = tick && (slot_cnt == '1);

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN)     presc_cnt <= '0;
      else if (tick) presc_cnt <= '0;
      else           presc_cnt <= presc_cnt + 1'b1;
   end

   // Slot counter wraps naturally at 2^DUTY_W; the wrap is the period boundary.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN)     slot_cnt <= '0;
      else if (tick) slot_cnt <= slot_cnt + 1'b1;
   end

   // PAUSE sampled on the same edge wins, freezing both step count and phase.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         step_cnt <= '0;
         phase_q  <= '0;
      end else if (boundary && !PAUSE) begin
         if (step_cnt == STEP_LAST) begin
            step_cnt <= '0;
            phase_q  <= phase_q + 1'b1;
         end else begin
            step_cnt <= step_cnt + 1'b1;
         end
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      localparam int              OFS   = i * PHASE_OFS;
      localparam logic [DUTY_W:0] OFS_V = OFS[DUTY_W:0];

      logic [DUTY_W:0] phase_ch;

      assign phase_ch = phase_q + OFS_V;

      breath_pwm_ch #(
         .DUTY_W(DUTY_W)
      ) u_ch (
         .clk  (CLK),
         .rst_n(RSTN),
         .load (boundary),
         .mode (MODE[2*i +: 2]),
         .phase(phase_ch),
         .slot (slot_cnt),
         .led  (LED[i])
      );
   end

endmodule

// File: tb/tb_breath_led_array.sv
// Directed bench for breath_led_array: per-period high-time tables plus
// hand-written reset, ON-latency and mid-period reset sequences.
module tb_breath_led_array;

   localparam int N_CH   = 4;
   localparam int PERIOD = 1000;

   logic              CLK  = 1'b0;
   logic              RSTN = 1'b0;
   logic [2*N_CH-1:0] MODE = '0;
   logic              PAUSE = 1'b0;
   logic [N_CH-1:0]   LED;

   always #5 CLK = ~CLK;

   breath_led_array #(
      .CLOCK_FRQ   (1000000),
      .PWM_FRQ     (1000),
      .DUTY_W      (3),
      .N_CH        (N_CH),
      .STEP_PERIODS(1),
      .PHASE_OFS   (4)
   ) dut (
      .CLK  (CLK),
      .RSTN (RSTN),
      .MODE (MODE),
      .PAUSE(PAUSE),
      .LED  (LED)
   );

   // One record per PWM period: MODE/PAUSE driven during it, expected high cycles per channel.
   typedef struct packed {
      logic [2*N_CH-1:0]     mode;
      logic                  pause;
      logic [N_CH-1:0][9:0]  exp_hi;
   } win_t;

   win_t vec_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   first_tick = -1;
   int   hi_cnt [N_CH];

   // High cycles per period for breath phase 0..15 (duty 0..7, 7..0, times 125 cycles).
   int tri_tbl [16] = '{0, 125, 250, 375, 500, 625, 750, 875,
                        875, 750, 625, 500, 375, 250, 125, 0};

   function automatic win_t mk(input logic [2*N_CH-1:0] mode, input logic pause,
                               input int e0, input int e1, input int e2, input int e3);
      win_t w;
      w.mode      = mode;
      w.pause     = pause;
      w.exp_hi[0] = 10'(e0);
      w.exp_hi[1] = 10'(e1);
      w.exp_hi[2] = 10'(e2);
      w.exp_hi[3] = 10'(e3);
      return w;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reset is asserted and released on falling edges so cycle 1 is the first rising edge after release.
   task automatic do_reset(input logic [2*N_CH-1:0] mode);
      @(negedge CLK);
      RSTN  = 1'b0;
      MODE  = mode;
      PAUSE = 1'b0;
      repeat (10) @(negedge CLK);
      check("led_during_reset", int'(LED), 0);
      RSTN       = 1'b1;
      cyc        = 0;
      first_tick = -1;
   endtask

   task automatic run_window(input logic [2*N_CH-1:0] mode, input logic pause);
      MODE  = mode;
      PAUSE = pause;
      for (int c = 0; c < N_CH; c++) hi_cnt[c] = 0;
      for (int k = 0; k < PERIOD; k++) begin
         @(negedge CLK);
         cyc++;
         // A tick seen here is acted on at the next rising edge.
         if (first_tick < 0 && dut.tick) first_tick = cyc + 1;
         for (int c = 0; c < N_CH; c++) if (LED[c]) hi_cnt[c]++;
      end
   endtask

   task automatic run_table(input string tag);
      for (int j = 0; j < vec_q.size(); j++) begin
         run_window(vec_q[j].mode, vec_q[j].pause);
         for (int c = 0; c < N_CH; c++)
            check($sformatf("%s_w%0d_ch%0d", tag, j, c), hi_cnt[c], int'(vec_q[j].exp_hi[c]));
      end
      vec_q.delete();
   endtask

   initial begin
      // All channels breathing from reset; period j is loaded with phase j-1.
      do_reset(8'hAA);
      vec_q.push_back(mk(8'hAA, 1'b0, 0, 0, 0, 0));
      for (int j = 1; j <= 17; j++) begin
         int p;
         p = j - 1;
         vec_q.push_back(mk(8'hAA, 1'b0, tri_tbl[p % 16], tri_tbl[(p + 4) % 16],
                            tri_tbl[(p + 8) % 16], tri_tbl[(p + 12) % 16]));
      end
      vec_q.push_back(mk(8'h37, 1'b0, 125, 625, 750, 250));
      // ch0 BLINK at phase 2 (on), ch1 ON, ch2 BLINK at phase 10 (off), ch3 OFF.
      vec_q.push_back(mk(8'h37, 1'b0, 1000, 1000, 0, 0));
      run_table("breath");
      check("first_tick_edge", first_tick, 125);

      // ON mode: dark for the whole first period, full on one cycle after the boundary.
      do_reset(8'h55);
      run_window(8'h55, 1'b0);
      for (int c = 0; c < N_CH; c++) check($sformatf("on_pre_ch%0d", c), hi_cnt[c], 0);
      check("on_last_pre_cycle", int'(LED), 0);
      @(negedge CLK);
      cyc++;
      check("on_first_cycle", int'(LED), 15);

      // PAUSE held over three boundaries while phase is 5.
      do_reset(8'h02);
      vec_q.push_back(mk(8'h02, 1'b0, 0, 0, 0, 0));
      vec_q.push_back(mk(8'h02, 1'b0, 0, 0, 0, 0));
      vec_q.push_back(mk(8'h02, 1'b0, 125, 0, 0, 0));
      vec_q.push_back(mk(8'h02, 1'b0, 250, 0, 0, 0));
      vec_q.push_back(mk(8'h02, 1'b0, 375, 0, 0, 0));
      vec_q.push_back(mk(8'h02, 1'b1, 500, 0, 0, 0));
      vec_q.push_back(mk(8'h02, 1'b1, 625, 0, 0, 0));
      vec_q.push_back(mk(8'h02, 1'b1, 625, 0, 0, 0));
      vec_q.push_back(mk(8'h02, 1'b0, 625, 0, 0, 0));
      vec_q.push_back(mk(8'h02, 1'b0, 625, 0, 0, 0));
      vec_q.push_back(mk(8'h02, 1'b0, 750, 0, 0, 0));
      run_table("pause");

      // Next period runs at duty 7; drop reset while ch0 is lit.
      repeat (100) @(negedge CLK);
      check("mid_reset_pre_high", int'(LED[0]), 1);
      #2;
      RSTN = 1'b0;
      #1;
      check("mid_reset_async_led", int'(LED), 0);
      repeat (5) @(negedge CLK);
      check("mid_reset_held_led", int'(LED), 0);
      RSTN       = 1'b1;
      cyc        = 0;
      first_tick = -1;
      vec_q.push_back(mk(8'h02, 1'b0, 0, 0, 0, 0));
      vec_q.push_back(mk(8'h02, 1'b0, 0, 0, 0, 0));
      vec_q.push_back(mk(8'h02, 1'b0, 125, 0, 0, 0));
      vec_q.push_back(mk(8'h02, 1'b0, 250, 0, 0, 0));
      run_table("restart");
      check("restart_first_tick_edge", first_tick, 125);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
